// File: rtl/e_mdu_if.sv
// rtl/e_mdu_if.sv - E-stage multiply/divide unit operation and HI/LO bus
interface e_mdu_if;
  logic [2:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        stall_req;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output MDUOp, A, B,
    input  busy, stall_req, HI, LO
  );

  modport slave (
    input  MDUOp, A, B,
    output busy, stall_req, HI, LO
  );
endinterface

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - fixed-latency multiply/divide unit holding architectural HI/LO
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic   clk,
  input logic   reset,
  e_mdu_if.slave bus
);

  localparam int unsigned CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int          CW   = $clog2(CMAX + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  state_e        state;

  // The operation phase is implied entirely by the remaining-cycle counter
  assign state = (cnt_q != '0) ? S_RUN : S_IDLE;

  // Arithmetic always works on the latched operands; live A/B may change while busy
  logic [63:0] prod_u, prod_s;
  logic [31:0] mag_a, mag_b, dvs_u, dvs_s;
  logic [31:0] quo_u, rem_u, mquo, mrem, quo_s, rem_s;

  // Signed divide is done on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing
  always_comb begin
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    mag_a  = a_q[31] ? (~a_q + 32'd1) : a_q;
    mag_b  = b_q[31] ? (~b_q + 32'd1) : b_q;
    dvs_u  = (b_q == 32'd0) ? 32'd1 : b_q;
    dvs_s  = (mag_b == 32'd0) ? 32'd1 : mag_b;
    quo_u  = a_q / dvs_u;
    rem_u  = a_q % dvs_u;
    mquo   = mag_a / dvs_s;
    mrem   = mag_a % dvs_s;
    quo_s  = (a_q[31] ^ b_q[31]) ? (~mquo + 32'd1) : mquo;
    rem_s  = a_q[31] ? (~mrem + 32'd1) : mrem;
  end

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      op_q  <= 3'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  // Next state: accept ops only when idle, commit the result on the last busy cycle
  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    case (state)
      S_IDLE: begin
        case (bus.MDUOp)
          OP_MULT, OP_MULTU: begin
            op_d  = bus.MDUOp;
            a_d   = bus.A;
            b_d   = bus.B;
            cnt_d = CW'(MULT_CYCLES);
          end
          OP_DIV, OP_DIVU: begin
            op_d  = bus.MDUOp;
            a_d   = bus.A;
            b_d   = bus.B;
            cnt_d = CW'(DIV_CYCLES);
          end
          OP_MTHI: hi_d = bus.A;
          OP_MTLO: lo_d = bus.A;
          default: ;
        endcase
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV: begin
              if (b_q != 32'd0) begin
                lo_d = quo_s;
                hi_d = rem_s;
              end
            end
            OP_DIVU: begin
              if (b_q != 32'd0) begin
                lo_d = quo_u;
                hi_d = rem_u;
              end
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  assign bus.busy      = (state == S_RUN);
  assign bus.stall_req = bus.busy || ((bus.MDUOp >= OP_MULT) && (bus.MDUOp <= OP_DIVU));
  assign bus.HI        = hi_q;
  assign bus.LO        = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - scoreboard testbench for e_mdu
module tb_e_mdu;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  e_mdu_if bus ();

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] hi_m, lo_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output int lat);
    longint      sa, sbv, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    h   = hi_m;
    l   = lo_m;
    lat = (op <= 3'd2) ? 5 : 10;
    case (op)
      3'd1: begin
        p = 64'(sa * sbv);
        h = p[63:32];
        l = p[31:0];
      end
      3'd2: begin
        p = 64'(a) * 64'(b);
        h = p[63:32];
        l = p[31:0];
      end
      3'd3: begin
        if (b != 32'd0) begin
          q = sa / sbv;
          r = sa % sbv;
          l = q[31:0];
          h = r[31:0];
        end
      end
      3'd4: begin
        if (b != 32'd0) begin
          l = a / b;
          h = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge of the first cycle with busy low
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit junk);
    exp_t e;
    int   n;
    bit   done;
    n    = 0;
    done = 1'b0;
    e.tag = tag;
    model(op, a, b, e.hi, e.lo, e.lat);
    sb_q.push_back(e);
    bus.MDUOp = op;
    bus.A     = a;
    bus.B     = b;
    #1 check({tag, "_stall"}, 64'(bus.stall_req), 64'd1);
    @(posedge clk);
    #1;
    bus.MDUOp = 3'd0;
    bus.A     = $urandom;
    bus.B     = $urandom;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.busy) begin
        n++;
        if (junk && n == 2) begin
          bus.MDUOp = 3'd6;
          bus.A     = 32'hDEADBEEF;
        end else if (junk && n == 3) begin
          bus.MDUOp = 3'd1;
          bus.A     = 32'd7;
          bus.B     = 32'd9;
        end else begin
          bus.MDUOp = 3'd0;
        end
      end else begin
        done = 1'b1;
      end
    end
    if (!done) check({tag, "_timeout"}, 64'd0, 64'd1);
    e = sb_q.pop_front();
    check({e.tag, "_busy_len"}, 64'(n), 64'(e.lat));
    check({e.tag, "_hi"}, 64'(bus.HI), 64'(e.hi));
    check({e.tag, "_lo"}, 64'(bus.LO), 64'(e.lo));
    hi_m = e.hi;
    lo_m = e.lo;
  endtask

  // Single-cycle register move (or no-op); called and returns at a negedge
  task automatic mt_op(input string tag, input logic [2:0] op, input logic [31:0] a);
    bus.MDUOp = op;
    bus.A     = a;
    #1 check({tag, "_stall"}, 64'(bus.stall_req), 64'd0);
    @(posedge clk);
    #1 bus.MDUOp = 3'd0;
    @(negedge clk);
    if (op == 3'd5) hi_m = a;
    if (op == 3'd6) lo_m = a;
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_hi"}, 64'(bus.HI), 64'(hi_m));
    check({tag, "_lo"}, 64'(bus.LO), 64'(lo_m));
  endtask

  initial begin
    bus.MDUOp = 3'd0;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    hi_m      = 32'd0;
    lo_m      = 32'd0;
    reset     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hi", 64'(bus.HI), 64'd0);
    check("rst_lo", 64'(bus.LO), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op("mult", 3'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
    run_op("multu", 3'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
    mt_op("nop7", 3'd7, 32'h55);
    run_op("div", 3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    run_op("divu", 3'd4, 32'd7, 32'd2, 1'b0);
    run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_op("mult_nn", 3'd1, 32'h80000000, 32'h80000000, 1'b0);
    mt_op("mthi", 3'd5, 32'h1234);
    run_op("divu_z", 3'd4, 32'd5, 32'd0, 1'b1);
    mt_op("mtlo", 3'd6, 32'hCAFE0001);
    run_op("mult_b2b0", 3'd1, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    run_op("mult_b2b1", 3'd1, 32'hFFFFFFFD, 32'd5, 1'b0);

    // Reset in busy cycle 4 of a divide must abort it with no later write
    bus.MDUOp = 3'd3;
    bus.A     = 32'd100;
    bus.B     = 32'd7;
    @(posedge clk);
    #1 bus.MDUOp = 3'd0;
    repeat (4) @(negedge clk);
    check("abort_busy_pre", 64'(bus.busy), 64'd1);
    reset = 1'b0;
    #1;
    check("abort_hi", 64'(bus.HI), 64'd0);
    check("abort_lo", 64'(bus.LO), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_post_busy", 64'(bus.busy), 64'd0);
    check("abort_post_hi", 64'(bus.HI), 64'd0);
    check("abort_post_lo", 64'(bus.LO), 64'd0);
    hi_m = 32'd0;
    lo_m = 32'd0;

    run_op("post_rst_multu", 3'd2, 32'd3, 32'd4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
